// File: rtl/pattern_scan_if.sv
// rtl/pattern_scan_if.sv - host-side configuration and word handshake bundle for pattern_scan_ctrl
//
// Purpose: groups the host configuration strobe and the word valid/ready
//          handshake into one bundle.
// Signals:
//   cfg_we       configuration write strobe (host -> controller)
//   cfg_pattern  new target pattern, PAT_W bits
//   cfg_overlap  1 = overlapping matches allowed
//   in_valid     host word valid
//   in_data      host word, DATA_W bits
//   in_last      word is last of frame, qualified by in_valid
//   in_ready     controller can accept a word (controller -> host)
interface pattern_scan_if #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, in_valid, in_data, in_last,
        input  in_ready
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, in_valid, in_data, in_last,
        output in_ready
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - frame-level controller for the serial pattern detector
//
// Purpose: accepts host words, serializes them MSB-first into a PAT_W-bit
//          detection window, matches against a programmable pattern and
//          counts matches per frame.
// Ports:
//   cp           clock, rising edge
//   reset        synchronous, active-high reset
//   host         pattern_scan_if slave: config strobe + word handshake
//   busy         high while shifting a word
//   window       current detection window, newest bit in LSB
//   hit          one-cycle pulse per match
//   match_count  saturating match count of current/last frame
//   done         one-cycle pulse at end of frame
module pattern_scan_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             cp,
    input  logic             reset,
    pattern_scan_if.slave    host,
    output logic             busy,
    output logic [PAT_W-1:0] window,
    output logic             hit,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic              last_q;
    logic [PAT_W-1:0]  window_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;
    logic              frame_start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              hit_q;
    logic              done_q;

    logic [PAT_W-1:0]  window_d;
    logic [FILL_W-1:0] fill_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              match;

    // Next window/fill for the bit being shifted this cycle; a match needs a
    // fully populated window so stale zeros after a clear never count.
    always_comb begin
        window_d = {window_q[PAT_W-2:0], shreg_q[DATA_W-1]};
        fill_d   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        match    = (fill_d == FILL_FULL) && (window_d == pattern_q);
        cnt_d    = (match && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge cp) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_idx_q     <= '0;
            last_q        <= 1'b0;
            window_q      <= '0;
            fill_q        <= '0;
            pattern_q     <= PAT_W'(4'b1101);
            overlap_q     <= 1'b1;
            frame_start_q <= 1'b1;
            cnt_q         <= '0;
            hit_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Config lands on the same edge as the word, so a
                    // simultaneous word is scanned with the new config.
                    if (host.cfg_we) begin
                        pattern_q <= host.cfg_pattern;
                        overlap_q <= host.cfg_overlap;
                    end
                    if (host.in_valid) begin
                        shreg_q   <= host.in_data;
                        last_q    <= host.in_last;
                        bit_idx_q <= IDX_W'(DATA_W - 1);
                        state_q   <= SHIFT;
                        if (frame_start_q) begin
                            cnt_q         <= '0;
                            frame_start_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    shreg_q   <= shreg_q << 1;
                    window_q  <= window_d;
                    // Non-overlap: window keeps showing the hit, but the
                    // next match needs a full fresh window.
                    fill_q    <= (match && !overlap_q) ? '0 : fill_d;
                    hit_q     <= match;
                    cnt_q     <= cnt_d;
                    bit_idx_q <= bit_idx_q - 1'b1;
                    if (bit_idx_q == '0) begin
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DONE: begin
                    window_q      <= '0;
                    fill_q        <= '0;
                    frame_start_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host.in_ready = (state_q == IDLE);
    assign busy          = (state_q == SHIFT);
    assign window        = window_q;
    assign hit           = hit_q;
    assign match_count   = cnt_q;
    assign done          = done_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;
    logic cp;
    logic reset;

    pattern_scan_if #(.DATA_W(8), .PAT_W(4)) hif0 ();
    pattern_scan_if #(.DATA_W(8), .PAT_W(4)) hif1 ();

    logic       busy0, hit0, done0;
    logic [3:0] window0;
    logic [7:0] cnt0;
    logic       busy1, hit1, done1;
    logic [3:0] window1;
    logic [1:0] cnt1;

    pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut0 (
        .cp(cp), .reset(reset), .host(hif0.slave), .busy(busy0),
        .window(window0), .hit(hit0), .match_count(cnt0), .done(done0)
    );

    pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(2)) dut1 (
        .cp(cp), .reset(reset), .host(hif1.slave), .busy(busy1),
        .window(window1), .hit(hit1), .match_count(cnt1), .done(done1)
    );

    assign hif1.cfg_we      = hif0.cfg_we;
    assign hif1.cfg_pattern = hif0.cfg_pattern;
    assign hif1.cfg_overlap = hif0.cfg_overlap;
    assign hif1.in_valid    = hif0.in_valid;
    assign hif1.in_data     = hif0.in_data;
    assign hif1.in_last     = hif0.in_last;

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] w;
        logic       h;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] m_win;
    int         m_fill;
    logic [3:0] m_pat;
    logic       m_ov;
    logic       m_fs;
    logic [7:0] m_cnt0;
    logic [1:0] m_cnt1;

    task automatic fail(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_win = 4'b0; m_fill = 0; m_pat = 4'b1101; m_ov = 1'b1; m_fs = 1'b1;
        m_cnt0 = 8'd0; m_cnt1 = 2'd0;
    endtask

    task automatic do_cfg(input logic [3:0] pat, input logic ov);
        @(negedge cp);
        hif0.cfg_we = 1'b1; hif0.cfg_pattern = pat; hif0.cfg_overlap = ov;
        @(posedge cp);
        @(negedge cp);
        hif0.cfg_we = 1'b0;
        m_pat = pat; m_ov = ov;
    endtask

    task automatic send_word(input logic [7:0] data, input logic last, input logic noise,
                             input logic with_cfg, input logic [3:0] c_pat, input logic c_ov,
                             output logic [7:0] hmask);
        int         waitc;
        exp_t       e;
        logic       b, mt;
        logic [3:0] wn;
        int         fn;
        waitc = 0;
        hmask = 8'h00;
        while (hif0.in_ready !== 1'b1 && waitc < 50) begin
            @(negedge cp);
            waitc++;
        end
        n_cmp++; if (hif0.in_ready !== 1'b1) fail("ready_before_word", hif0.in_ready, 1'b1);
        hif0.in_valid = 1'b1; hif0.in_data = data; hif0.in_last = last;
        if (with_cfg) begin
            hif0.cfg_we = 1'b1; hif0.cfg_pattern = c_pat; hif0.cfg_overlap = c_ov;
            m_pat = c_pat; m_ov = c_ov;
        end
        if (m_fs) begin
            m_cnt0 = 8'd0; m_cnt1 = 2'd0; m_fs = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            b  = data[7-k];
            wn = {m_win[2:0], b};
            fn = (m_fill == 4) ? 4 : m_fill + 1;
            mt = (fn == 4) && (wn == m_pat);
            m_win  = wn;
            m_fill = (mt && !m_ov) ? 0 : fn;
            if (mt) begin
                if (m_cnt0 != 8'hFF) m_cnt0++;
                if (m_cnt1 != 2'd3)  m_cnt1++;
            end
            e.w = wn; e.h = mt; e.d = last && (k == 7);
            q.push_back(e);
        end
        @(posedge cp);
        @(negedge cp);
        hif0.in_valid = noise;
        hif0.cfg_we   = noise;
        if (noise) hif0.cfg_pattern = 4'b0000;
        n_cmp++; if (busy0 !== 1'b1) fail("busy_after_accept", busy0, 1'b1);
        n_cmp++; if (hif0.in_ready !== 1'b0) fail("ready_low_in_shift", hif0.in_ready, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                hif0.in_valid = 1'b0; hif0.cfg_we = 1'b0;
            end
            @(posedge cp);
            @(negedge cp);
            e = q.pop_front();
            n_cmp++; if (window0 !== e.w) fail("window", window0, e.w);
            n_cmp++; if (hit0 !== e.h) fail("hit", hit0, e.h);
            n_cmp++; if (done0 !== e.d) fail("done", done0, e.d);
            n_cmp++; if (window1 !== e.w) fail("window_c2", window1, e.w);
            n_cmp++; if (hit1 !== e.h) fail("hit_c2", hit1, e.h);
            hmask[k] = hit0;
        end
        n_cmp++; if (cnt0 !== m_cnt0) fail("match_count", cnt0, m_cnt0);
        n_cmp++; if (cnt1 !== m_cnt1) fail("match_count_c2", cnt1, m_cnt1);
        if (!last) begin
            n_cmp++; if (hif0.in_ready !== 1'b1) fail("ready_after_word", hif0.in_ready, 1'b1);
            n_cmp++; if (busy0 !== 1'b0) fail("busy_after_word", busy0, 1'b0);
        end else begin
            m_win = 4'b0; m_fill = 0; m_fs = 1'b1;
            @(negedge cp);
            n_cmp++; if (done0 !== 1'b0) fail("done_one_cycle", done0, 1'b0);
            n_cmp++; if (hif0.in_ready !== 1'b1) fail("ready_after_done", hif0.in_ready, 1'b1);
            n_cmp++; if (window0 !== 4'b0000) fail("window_cleared", window0, 4'b0000);
            n_cmp++; if (cnt0 !== m_cnt0) fail("count_held", cnt0, m_cnt0);
        end
    endtask

    logic [7:0] hm;

    initial begin
        hif0.cfg_we = 1'b0; hif0.cfg_pattern = 4'b0; hif0.cfg_overlap = 1'b0;
        hif0.in_valid = 1'b0; hif0.in_data = 8'h00; hif0.in_last = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge cp);
        @(negedge cp);
        reset = 1'b0;
        @(negedge cp);
        n_cmp++; if (hif0.in_ready !== 1'b1) fail("rst_in_ready", hif0.in_ready, 1'b1);
        n_cmp++; if (busy0 !== 1'b0) fail("rst_busy", busy0, 1'b0);
        n_cmp++; if (hit0 !== 1'b0) fail("rst_hit", hit0, 1'b0);
        n_cmp++; if (done0 !== 1'b0) fail("rst_done", done0, 1'b0);
        n_cmp++; if (window0 !== 4'b0000) fail("rst_window", window0, 4'b0000);
        n_cmp++; if (cnt0 !== 8'd0) fail("rst_count", cnt0, 8'd0);

        send_word(8'b11011010, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b0100_1000) fail("default_hits", hm, 8'b0100_1000);
        n_cmp++; if (cnt0 !== 8'd2) fail("default_count", cnt0, 8'd2);

        do_cfg(4'b1010, 1'b1);
        send_word(8'hAA, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b1010_1000) fail("aa_overlap_hits", hm, 8'b1010_1000);
        n_cmp++; if (cnt0 !== 8'd3) fail("aa_overlap_count", cnt0, 8'd3);

        do_cfg(4'b1010, 1'b0);
        send_word(8'hAA, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b1000_1000) fail("aa_nonoverlap_hits", hm, 8'b1000_1000);
        n_cmp++; if (cnt0 !== 8'd2) fail("aa_nonoverlap_count", cnt0, 8'd2);

        do_cfg(4'b1101, 1'b1);
        send_word(8'b00000110, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'h00) fail("cross_first_hits", hm, 8'h00);
        send_word(8'b10000000, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b0000_0001) fail("cross_second_hits", hm, 8'b0000_0001);
        n_cmp++; if (cnt0 !== 8'd1) fail("cross_count", cnt0, 8'd1);

        do_cfg(4'b1101, 1'b0);
        send_word(8'b11011010, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b0000_1000) fail("nonoverlap_1101_hits", hm, 8'b0000_1000);
        n_cmp++; if (cnt0 !== 8'd1) fail("pre_reset_count", cnt0, 8'd1);

        @(negedge cp);
        hif0.in_valid = 1'b1; hif0.in_data = 8'b11011010; hif0.in_last = 1'b1;
        @(posedge cp);
        @(negedge cp);
        hif0.in_valid = 1'b0;
        @(posedge cp);
        @(negedge cp);
        reset = 1'b1;
        @(posedge cp);
        @(negedge cp);
        reset = 1'b0;
        model_reset();
        n_cmp++; if (hif0.in_ready !== 1'b1) fail("midreset_in_ready", hif0.in_ready, 1'b1);
        n_cmp++; if (busy0 !== 1'b0) fail("midreset_busy", busy0, 1'b0);
        n_cmp++; if (window0 !== 4'b0000) fail("midreset_window", window0, 4'b0000);
        n_cmp++; if (cnt0 !== 8'd0) fail("midreset_count", cnt0, 8'd0);
        n_cmp++; if (hit0 !== 1'b0) fail("midreset_hit", hit0, 1'b0);

        send_word(8'b11011010, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, hm);
        n_cmp++; if (hm !== 8'b0100_1000) fail("post_reset_hits", hm, 8'b0100_1000);
        n_cmp++; if (cnt0 !== 8'd2) fail("post_reset_count", cnt0, 8'd2);

        send_word(8'hFF, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, hm);
        n_cmp++; if (hm !== 8'b1111_1000) fail("ff_hits", hm, 8'b1111_1000);
        n_cmp++; if (cnt0 !== 8'd5) fail("ff_count_wide", cnt0, 8'd5);
        n_cmp++; if (cnt1 !== 2'd3) fail("ff_count_saturated", cnt1, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
